multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and write-back, and drives every control input of the datapath. It sits directly upstream of the datapath: it consumes the fetched instruction word and the datapath `Zero` flag. It produces `PCSrc`, `ALUSrc`, `RegWrite`, `MemToReg`, `loadPC` and `ALUCtrl`, plus the data-memory `MemRead`/`MemWrite` strobes.

## Interface
- `SW`, 7'b0100011, store opcode
- `LW`, 7'b0000011, load opcode
- `IMMEDIATE`, 7'b0010011, register-immediate ALU opcode
- `BEQ`, 7'b1100011, branch-if-equal opcode
- `RR`, 7'b0110011, register-register ALU opcode
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `instr`  input  32  instruction word at current PC
- `Zero`  input  1  datapath ALU zero flag
- `PCSrc`  output  1  1 = PC+branch offset, 0 = PC+4
- `ALUSrc`  output  1  1 = immediate as ALU op2
- `RegWrite`  output  1  register-file write enable
- `MemToReg`  output  1  1 = write back memory data
- `loadPC`  output  1  PC update enable
- `ALUCtrl`  output  4  ALU operation code
- `MemRead`  output  1  data-memory read strobe
- `MemWrite`  output  1  data-memory write strobe

## Operation
- States: IF → ID → EX → MEM → WB → IF. Every instruction takes all five states, including BEQ and RR.
- On the IF→ID edge, `instr` is latched into `instr_q`. All decoding uses `instr_q`.
- Static decode outputs are valid from ID through WB. In IF they are 0, and `ALUCtrl` is ADD.
  - `ALUSrc` = 1 for LW, SW and IMMEDIATE.
  - `MemToReg` = 1 for LW.
- `ALUCtrl` codes: AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000.
- `ALUCtrl` decode by instruction type:
  - RR: funct3/funct7[5] select the code. 000/0 = ADD, 000/1 = SUB, 001 = SLL, 010 = SLT, 100 = XOR, 101/0 = SRL, 101/1 = SRA, 110 = OR, 111 = AND.
  - IMMEDIATE: same mapping, except funct3=000 is always ADD. funct7[5] is honoured only for 101.
  - LW and SW: ADD.
  - BEQ: SUB.
  - Unlisted RR funct3/funct7 combinations: ADD.
- `MemRead` = 1 only in MEM for LW. `MemWrite` = 1 only in MEM for SW.
- `RegWrite` = 1 only in WB for LW, IMMEDIATE and RR.
- `loadPC` = 1 only in WB.
- `PCSrc` = (opcode == BEQ) & `Zero`, evaluated in WB only; 0 elsewhere.
- Unknown opcode: treated as a NOP. No strobes fire; `loadPC` still fires in WB, so PC advances by 4.

## Timing
- Reset (`rst` low, asynchronous): state = IF, `instr_q` = 0, all 1-bit outputs 0, `ALUCtrl` = 0010.
- Reset asserted mid-instruction aborts it immediately; no write or memory strobe completes.
- First IF occurs in the first cycle after `rst` deasserts.
- Throughput is one instruction per 5 cycles. The PC changes at the rising edge that ends WB.
- All outputs are Moore-style functions of state and `instr_q`, with one exception: `PCSrc` depends combinationally on `Zero` in WB.
- `Zero` must be stable by WB. The datapath registers it during EX and MEM.
- `instr` must be stable at the IF→ID edge. Changes to `instr` in ID–WB are ignored.

## Configuration
- `ILLEGAL_HALT_EN` defined:
  - Adds output `illegal` (1 bit) and state HALT.
  - An unknown opcode in ID pulses `illegal` for one cycle. The FSM then enters HALT instead of EX.
  - HALT holds all outputs at their reset values and is left only by `rst`.
- `ILLEGAL_HALT_EN` undefined: no `illegal` port and no HALT state. Unknown opcodes are NOPs as described above.

## Structure
- Shared package holds:
  - opcode constants;
  - the `ALUCtrl` code constants, shared with the ALU;
  - the FSM state typedef;
  - funct3 constants.
- One combinational sub-module, `alu_decoder`: (opcode, funct3, funct7[5]) → `ALUCtrl`.

## Test plan
- `add x3,x1,x2` (0x002081B3) → `ALUCtrl` = 0010 and `ALUSrc` = 0 from ID; `RegWrite` = 1 and `loadPC` = 1 in WB only; `PCSrc` = 0.
- `sub x3,x1,x2` (0x402081B3) → `ALUCtrl` = 0110; `RegWrite` pulses for one cycle, in WB.
- `lw x5,8(x1)` (0x0080A283) → `ALUSrc` = 1 and `MemToReg` = 1; `MemRead` = 1 in MEM; `RegWrite` = 1 in WB; `MemWrite` never asserts.
- `sw x2,4(x1)` (0x0020A223) → `MemWrite` = 1 in MEM only; `RegWrite` never asserts.
- `beq` (0x00208463):
  - with `Zero` = 1 → `PCSrc` = 1 and `loadPC` = 1 in WB; `ALUCtrl` = 0110.
  - repeated with `Zero` = 0 → `PCSrc` = 0.
- 0xFFFFFFFF followed by `rst` pulsed low during MEM of the next instruction:
  - Without the macro: the unknown word completes as a NOP with only `loadPC` in WB.
  - With `ILLEGAL_HALT_EN`: one `illegal` pulse, then HALT; `loadPC` stays 0 for more than 10 cycles.
  - After the reset pulse: all outputs return to 0 / 0010 asynchronously, and IF follows.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control FSM and its ALU decoder.
// Optional feature macro: ILLEGAL_HALT_EN adds the HALT state.
package multicycle_control_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned ALU_CTRL_W = 4;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_RR  = 7'b0110011;

    // ALU operation codes, shared with the ALU
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'b1000;

    // funct3 field values
    localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_SLL     = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_SLT     = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_XOR     = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_SRL_SRA = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB
`ifdef ILLEGAL_HALT_EN
        , S_HALT
`endif
    } state_t;

    // True for every opcode the control unit implements
    function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_SW) || (op == OP_LW) || (op == OP_IMM) ||
               (op == OP_BEQ) || (op == OP_RR);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU control decode from opcode, funct3 and funct7[5].
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT3_W-1:0]   funct3,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_c
);

    // Map instruction fields to an ALU operation; anything unlisted adds
    always_comb begin
        alu_ctrl_c = ALU_ADD;
        case (opcode)
            OP_RR, OP_IMM: begin
                case (funct3)
                    F3_ADD_SUB: alu_ctrl_c = ((opcode == OP_RR) && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     alu_ctrl_c = ALU_SLL;
                    F3_SLT:     alu_ctrl_c = ALU_SLT;
                    F3_XOR:     alu_ctrl_c = ALU_XOR;
                    F3_SRL_SRA: alu_ctrl_c = funct7_5 ? ALU_SRA : ALU_SRL;
                    F3_OR:      alu_ctrl_c = ALU_OR;
                    F3_AND:     alu_ctrl_c = ALU_AND;
                    default:    alu_ctrl_c = ALU_ADD;
                endcase
            end
            OP_BEQ:  alu_ctrl_c = ALU_SUB;
            default: alu_ctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: IF -> ID -> EX -> MEM -> WB for every instruction.
// Optional feature macro: ILLEGAL_HALT_EN (illegal output + sticky HALT state).
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  Zero,
    output logic                  PCSrc,
    output logic                  ALUSrc,
    output logic                  RegWrite,
    output logic                  MemToReg,
    output logic                  loadPC,
    output logic [ALU_CTRL_W-1:0] ALUCtrl,
    output logic                  MemRead,
    output logic                  MemWrite
`ifdef ILLEGAL_HALT_EN
    ,
    output logic                  illegal
`endif
);

    state_t               state_q;
    state_t               state_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [OPCODE_W-1:0]  opcode;
    logic [ALU_CTRL_W-1:0] alu_ctrl_c;
    logic                 is_lw;
    logic                 is_sw;
    logic                 is_imm;
    logic                 is_rr;
    logic                 is_beq;
    logic                 unused_instr_bits;

    assign opcode = instr_q[OPCODE_W-1:0];
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_imm = (opcode == OP_IMM);
    assign is_rr  = (opcode == OP_RR);
    assign is_beq = (opcode == OP_BEQ);

    // Register and immediate fields belong to the datapath, not to control
    assign unused_instr_bits = ^{instr_q[31], instr_q[29:15], instr_q[11:7]};

    alu_decoder u_alu_decoder (
        .opcode     (opcode),
        .funct3     (instr_q[14:12]),
        .funct7_5   (instr_q[30]),
        .alu_ctrl_c (alu_ctrl_c)
    );

    // State register; the instruction is captured on the edge that leaves IF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF) begin
                instr_q <= instr;
            end
        end
    end

    // Next state and Moore decode of the datapath controls
    always_comb begin
        state_d  = state_q;
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        loadPC   = 1'b0;
        ALUCtrl  = ALU_ADD;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
`ifdef ILLEGAL_HALT_EN
        illegal  = 1'b0;
`endif
        if ((state_q == S_ID) || (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB)) begin
            ALUSrc   = is_lw | is_sw | is_imm;
            MemToReg = is_lw;
            ALUCtrl  = alu_ctrl_c;
        end
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                state_d = S_EX;
`ifdef ILLEGAL_HALT_EN
                if (!is_known_op(opcode)) begin
                    illegal = 1'b1;
                    state_d = S_HALT;
                end
`endif
            end
            S_EX: state_d = S_MEM;
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                state_d  = S_WB;
            end
            S_WB: begin
                RegWrite = is_lw | is_imm | is_rr;
                loadPC   = 1'b1;
                PCSrc    = is_beq & Zero;
                state_d  = S_IF;
            end
`ifdef ILLEGAL_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IF;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: phase-counting reference model plus directed vectors.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        Zero = 1'b0;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
    logic [3:0]  ALUCtrl;
`ifdef ILLEGAL_HALT_EN
    logic        illegal;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [10:0] RESET_OUTS = 11'b00000_0010_00;

    multicycle_control dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .Zero     (Zero),
        .PCSrc    (PCSrc),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .MemToReg (MemToReg),
        .loadPC   (loadPC),
        .ALUCtrl  (ALUCtrl),
        .MemRead  (MemRead),
        .MemWrite (MemWrite)
`ifdef ILLEGAL_HALT_EN
        ,
        .illegal  (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [10:0] outs_now();
        return {PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl, MemRead, MemWrite};
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        return op == 7'b0100011 || op == 7'b0000011 || op == 7'b0010011 ||
               op == 7'b1100011 || op == 7'b0110011;
    endfunction

    // Expected outputs for an instruction word at a given phase (0=IF .. 4=WB)
    function automatic logic [10:0] model_out(input logic [31:0] w, input int phase, input logic z);
        logic [6:0] op;
        logic [2:0] f3;
        logic lw, sw, imm, rr, beq;
        logic [3:0] alu;
        op  = w[6:0];
        f3  = w[14:12];
        lw  = (op == 7'b0000011);
        sw  = (op == 7'b0100011);
        imm = (op == 7'b0010011);
        rr  = (op == 7'b0110011);
        beq = (op == 7'b1100011);
        alu = 4'b0010;
        if (rr || imm) begin
            case (f3)
                3'd0: alu = (rr && w[30]) ? 4'b0110 : 4'b0010;
                3'd1: alu = 4'b0011;
                3'd2: alu = 4'b0111;
                3'd4: alu = 4'b0100;
                3'd5: alu = w[30] ? 4'b1000 : 4'b0101;
                3'd6: alu = 4'b0001;
                3'd7: alu = 4'b0000;
                default: alu = 4'b0010;
            endcase
        end
        if (beq) alu = 4'b0110;
        if (phase == 0) return RESET_OUTS;
        return {(phase == 4) && beq && z, lw || sw || imm, (phase == 4) && (lw || imm || rr),
                lw, phase == 4, alu, (phase == 3) && lw, (phase == 3) && sw};
    endfunction

    // Reference model: cycles since reset and the instruction captured at end of IF
    int          cyc = 0;
    logic [31:0] m_instr = 32'h0;
    bit          halted = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc     <= 0;
            m_instr <= 32'h0;
            halted  <= 1'b0;
        end else begin
            if (cyc % 5 == 0) m_instr <= instr;
`ifdef ILLEGAL_HALT_EN
            if (!halted && cyc % 5 == 1 && !known_op(m_instr[6:0])) halted <= 1'b1;
`endif
            cyc <= cyc + 1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        logic [10:0] exp_v;
        exp_v = halted ? RESET_OUTS : model_out(m_instr, cyc % 5, Zero);
        check("model_outs", 32'(outs_now()), 32'(exp_v));
`ifdef ILLEGAL_HALT_EN
        check("model_illegal", 32'(illegal),
              32'(!halted && rst && (cyc % 5 == 1) && !known_op(m_instr[6:0])));
`endif
    end

    // One instruction through all five phases; entered during IF at posedge+2
    task automatic run_instr(input logic [31:0] word, input logic z, input logic [3:0] exp_alu,
                             input logic [1:0] exp_mem, input logic [2:0] exp_wb);
        instr = word;
        Zero  = z;
        @(posedge clk); #2;
        instr = $urandom;
        #1;
        check("id_aluctrl", 32'(ALUCtrl), 32'(exp_alu));
        check("id_regwrite", 32'(RegWrite), 32'h0);
        @(posedge clk); #3;
        @(posedge clk); #3;
        check("mem_strobes", 32'({MemRead, MemWrite}), 32'(exp_mem));
        @(posedge clk); #3;
        check("wb_pcsrc_regwr_loadpc", 32'({PCSrc, RegWrite, loadPC}), 32'(exp_wb));
        @(posedge clk); #2;
    endtask

    initial begin
        instr = 32'h002081B3;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outs", 32'(outs_now()), 32'(RESET_OUTS));
        rst = 1'b1;

        run_instr(32'h002081B3, 1'b0, 4'b0010, 2'b00, 3'b011); // add
        run_instr(32'h402081B3, 1'b0, 4'b0110, 2'b00, 3'b011); // sub
        run_instr(32'h0080A283, 1'b0, 4'b0010, 2'b10, 3'b011); // lw
        run_instr(32'h0020A223, 1'b0, 4'b0010, 2'b01, 3'b001); // sw
        run_instr(32'h00208463, 1'b1, 4'b0110, 2'b00, 3'b101); // beq taken
        run_instr(32'h00208463, 1'b0, 4'b0110, 2'b00, 3'b001); // beq not taken
        run_instr(32'h40315093, 1'b0, 4'b1000, 2'b00, 3'b011); // srai
        run_instr(32'hC0010093, 1'b0, 4'b0010, 2'b00, 3'b011); // addi, bit30 set
        run_instr(32'h0020B1B3, 1'b0, 4'b0010, 2'b00, 3'b011); // unlisted RR funct3

`ifdef ILLEGAL_HALT_EN
        instr = 32'hFFFFFFFF;
        @(posedge clk); #3;
        check("illegal_pulse", 32'(illegal), 32'h1);
        @(posedge clk); #3;
        check("illegal_cleared", 32'(illegal), 32'h0);
        for (int i = 0; i < 12; i++) begin
            check("halt_loadpc", 32'(loadPC), 32'h0);
            @(posedge clk); #3;
        end
`else
        run_instr(32'hFFFFFFFF, 1'b0, 4'b0010, 2'b00, 3'b001);  // unknown word: NOP
        instr = 32'h0080A283;
        repeat (3) @(posedge clk);
        #3;
        check("lw_mem_before_abort", 32'(MemRead), 32'h1);
`endif
        rst = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs_now()), 32'(RESET_OUTS));
        #3;
        instr = 32'h002081B3;
        rst = 1'b1;

        run_instr(32'h002081B3, 1'b0, 4'b0010, 2'b00, 3'b011); // add after reset
        run_instr(32'h0020A223, 1'b0, 4'b0010, 2'b01, 3'b001); // sw after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
